vvalu_config_sequencer: RTL

VVALU_CONFIG_SEQUENCER -- requirements
Module: vvalu_config_sequencer

---
 rtl/vvalu_config_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vvalu_config_sequencer.sv
// Sequences one firmware-field write into a traced ALU: stops tracing, waits for
// the pipeline to drain, broadcasts field/chain/value, then hands tracing back.
module vvalu_config_sequencer #(
  parameter int unsigned MAX_CHAINS   = 4,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned NUM_FIELDS   = 5,
  localparam int unsigned CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tracing_req,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_target,
  input  logic [2:0]    cmd_field,
  input  logic [CW-1:0] cmd_chain,
  input  logic [7:0]    cmd_value,
  output logic          cmd_ready,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [7:0]    configData,
  output logic          config_valid,
  output logic          busy,
  output logic          err
);

  localparam int unsigned DW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [7:0]  IDLE_ID = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SEND,
    S_RESUME
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      tgt_q, tgt_d;
  logic [2:0]      fld_q, fld_d;
  logic [CW-1:0]   chn_q, chn_d;
  logic [7:0]      val_q, val_d;

  logic            cmd_ready_d, tracing_d, config_valid_d, busy_d, err_d;
  logic [7:0]      config_id_d, config_data_d;

  logic            handshake;
  logic            illegal;

  assign handshake = (state_q == S_IDLE) && cmd_valid && cmd_ready;
  assign illegal   = (32'(cmd_field) >= NUM_FIELDS) || (32'(cmd_chain) >= MAX_CHAINS);

  // Next state plus next-cycle output values (outputs are decoded from state_d)
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    tgt_d          = tgt_q;
    fld_d          = fld_q;
    chn_d          = chn_q;
    val_d          = val_q;
    err_d          = err;
    cmd_ready_d    = 1'b0;
    tracing_d      = 1'b0;
    config_valid_d = 1'b0;
    busy_d         = 1'b0;
    config_id_d    = IDLE_ID;
    config_data_d  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          tgt_d = cmd_target;
          fld_d = cmd_field;
          chn_d = cmd_chain;
          val_d = cmd_value;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = DW'(DRAIN_CYCLES - 1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_SEND;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      S_SEND: begin
        if (idx_q == 2'd2) begin
          state_d = S_RESUME;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_RESUME: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    tracing_d   = (state_d == S_IDLE) ? tracing_req : 1'b0;
    busy_d      = (state_d != S_IDLE);

    if (state_d == S_SEND) begin
      config_valid_d = 1'b1;
      config_id_d    = tgt_d;
      case (idx_d)
        2'd0:    config_data_d = 8'(fld_d);
        2'd1:    config_data_d = 8'(chn_d);
        default: config_data_d = val_d;
      endcase
    end
  end

  // State and registered outputs; reset also discards any latched command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      tgt_q        <= '0;
      fld_q        <= '0;
      chn_q        <= '0;
      val_q        <= '0;
      cmd_ready    <= 1'b0;
      tracing      <= 1'b0;
      configId     <= IDLE_ID;
      configData   <= 8'h00;
      config_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      tgt_q        <= tgt_d;
      fld_q        <= fld_d;
      chn_q        <= chn_d;
      val_q        <= val_d;
      cmd_ready    <= cmd_ready_d;
      tracing      <= tracing_d;
      configId     <= config_id_d;
      configData   <= config_data_d;
      config_valid <= config_valid_d;
      busy         <= busy_d;
      err          <= err_d;
    end
  end

endmodule
